bf_out_serializer: RTL and testbench
====================================

// Module: bf_out_serializer
// PURPOSE
// - Sits directly downstream of the first butterfly/twiddle stage (512-pt, 16-lane R2SDF pipeline).
// - That stage emits add and sub results together for 16 cycles per frame.
// - This block re-times them into one continuous 16-lane stream for the next butterfly stage:
//   16 cycles of add vectors, then 16 cycles of sub vectors replayed from a 16-deep buffer.
// - The replay overlaps the upstream fill phase of the next frame, so a back-to-back frame stream stays gapless.
// PARAMETERS
// - DATA_WIDTH  10  width of each signed I/Q sample (upstream stage output width)
// - NUM_IN_OUT  16  lanes per cycle
// - BLK_DEPTH   16  cycles per half-frame; size of the sub buffer (power of 2)
// PORTS
// - clk            in   1                       clock
// - rstn           in   1                       async active-low reset
// - in_valid       in   1                       add/sub inputs valid this cycle
// - din_R_add      in   DATA_WIDTH x NUM_IN_OUT  real add results, signed
// - din_R_sub      in   DATA_WIDTH x NUM_IN_OUT  real sub results, signed
// - din_Q_add      in   DATA_WIDTH x NUM_IN_OUT  imag add results, signed
// - din_Q_sub      in   DATA_WIDTH x NUM_IN_OUT  imag sub results, signed
// - dout_i         out  DATA_WIDTH x NUM_IN_OUT  real output stream, signed
// - dout_q         out  DATA_WIDTH x NUM_IN_OUT  imag output stream, signed
// - dout_valid     out  1                       dout_i/dout_q valid
// - dout_sub_phase out  1                       1 = current output is a replayed sub vector
// - frame_done     out  1                       1-cycle pulse with the last sub vector of a frame
// - err_overrun    out  1                       sticky: in_valid seen while draining
// BEHAVIOUR
// - Clock and reset: one clock, clk. rstn is asynchronous, active-low.
// - Reset values:
//   - Outputs (dout_i, dout_q, dout_valid, dout_sub_phase, frame_done, err_overrun) all 0.
//   - State = IDLE, cnt = 0.
//   - Sub buffer contents are not reset and are don't-care.
// - Mid-operation reset: a reset during any state aborts the frame immediately. No partial drain afterwards.
// - State machine: IDLE, PASS, DRAIN. cnt is log2(BLK_DEPTH) bits wide.
// - IDLE / PASS, edge with in_valid=1:
//   - dout_i <= din_R_add; dout_q <= din_Q_add.
//   - buf_i[cnt] <= din_R_sub; buf_q[cnt] <= din_Q_sub.
//   - dout_valid <= 1; dout_sub_phase <= 0; cnt <= cnt+1.
//   - Next state PASS, or DRAIN with cnt <= 0 when cnt == BLK_DEPTH-1.
// - IDLE / PASS, edge with in_valid=0:
//   - Stall: cnt and state hold; dout_valid <= 0; dout data holds its last value.
//   - Gaps inside PASS are legal.
// - DRAIN, every edge (independent of in_valid):
//   - dout_i <= buf_i[cnt]; dout_q <= buf_q[cnt].
//   - dout_valid <= 1; dout_sub_phase <= 1; cnt <= cnt+1.
//   - When cnt == BLK_DEPTH-1: frame_done <= 1, next state IDLE, cnt <= 0.
// - Latency: 1 clock from input to output for add vectors.
//   Sub vector k appears BLK_DEPTH cycles after its add vector when input is gapless.
// - Overrun: in_valid=1 on any DRAIN edge sets err_overrun (sticky until reset).
//   That input is dropped; the drain continues unaffected.
// - Back-to-back frames: next frame's first in_valid is accepted on the edge after the last DRAIN edge,
//   giving a continuous 32-cycle output period.
// - Timing: frame_done and dout_sub_phase are registered and aligned with dout.
//   frame_done is 0 on all other edges.
// - No arithmetic: samples pass bit-exact. Input width = output width; no rounding or saturation.
// TESTING
// - Reset: rstn=0 mid-PASS at cnt=7 -> all outputs 0 asynchronously.
//   After release, the next in_valid burst restarts at cnt=0 with no stale sub output.
// - Single frame: lane0 add=k, sub=100+k for k=0..15 with in_valid continuous ->
//   - dout_i lane0 = 0..15 then 100..115 on 32 consecutive cycles;
//   - dout_sub_phase 0 then 1;
//   - frame_done on the cycle with 115.
// - Back-to-back: 3 frames, each 16 valid cycles then 16 idle ->
//   dout_valid stays high for 96 consecutive cycles; err_overrun = 0.
// - Stall: in_valid low for 3 cycles after the 5th vector ->
//   - dout_valid low 3 cycles and data held;
//   - remaining 11 add vectors follow;
//   - drain still outputs all 16 subs in order.
// - Overrun: in_valid high on DRAIN cycle 4 ->
//   err_overrun=1 and stays 1; drain output is unchanged (100..115).
// - Signed extremes: add=-512, sub=+511 on all lanes, I and Q -> bit-exact -512 / +511 on dout.

Source files
------------

// File: rtl/bf_out_serializer.sv
// -----------------------------------------------------------------------------
// bf_out_serializer
//
// This block sits after the first butterfly/twiddle stage of a 512-point,
// 16-lane R2SDF pipeline. That stage produces its add and sub results on the
// same cycles. This block turns them into one 16-lane stream for the next
// stage.
//
// Each frame has two halves:
//   - PASS: add vectors go straight to the output with 1 cycle of latency.
//     The matching sub vectors are written into a BLK_DEPTH-deep buffer.
//   - DRAIN: the buffered sub vectors are replayed for BLK_DEPTH cycles,
//     whatever in_valid does.
//
// The drain overlaps the upstream fill phase of the next frame, so a
// back-to-back frame stream leaves no gaps on the output.
//
// Samples pass through unchanged, bit for bit. The signed I/Q values are
// carried as plain bit vectors.
//
// Ports
//   clk, rstn          clock; asynchronous active-low reset
//   in_valid           add/sub inputs are valid this cycle
//   din_R_add/_sub     real add / sub results, NUM_IN_OUT lanes x DATA_WIDTH
//   din_Q_add/_sub     imag add / sub results, NUM_IN_OUT lanes x DATA_WIDTH
//   dout_i, dout_q     real / imag output stream
//   dout_valid         dout_i/dout_q hold a valid vector
//   dout_sub_phase     the current output is a replayed sub vector
//   frame_done         1-cycle pulse, aligned with the last sub vector
//   err_overrun        sticky; set when in_valid is seen while draining
// -----------------------------------------------------------------------------
module bf_out_serializer #(
    parameter int DATA_WIDTH = 10,
    parameter int NUM_IN_OUT = 16,
    parameter int BLK_DEPTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 in_valid,
    input  logic [NUM_IN_OUT-1:0][DATA_WIDTH-1:0] din_R_add,
    input  logic [NUM_IN_OUT-1:0][DATA_WIDTH-1:0] din_R_sub,
    input  logic [NUM_IN_OUT-1:0][DATA_WIDTH-1:0] din_Q_add,
    input  logic [NUM_IN_OUT-1:0][DATA_WIDTH-1:0] din_Q_sub,
    output logic [NUM_IN_OUT-1:0][DATA_WIDTH-1:0] dout_i,
    output logic [NUM_IN_OUT-1:0][DATA_WIDTH-1:0] dout_q,
    output logic                                 dout_valid,
    output logic                                 dout_sub_phase,
    output logic                                 frame_done,
    output logic                                 err_overrun
);

    localparam int CNT_W = $clog2(BLK_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DRAIN
    } state_t;

    typedef logic [NUM_IN_OUT-1:0][DATA_WIDTH-1:0] vec_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_add;   // accept one add/sub pair this edge
    logic             load_sub;   // replay one buffered sub vector this edge
    logic             done_d;

    vec_t buf_i [BLK_DEPTH];
    vec_t buf_q [BLK_DEPTH];

    // Next-state and control decode.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_add = 1'b0;
        load_sub = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE, PASS: begin
                if (in_valid) begin
                    load_add = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = PASS;
                    end
                end
            end
            DRAIN: begin
                load_sub = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: non-blocking assignments here, so every register samples the pre-edge values regardless of statement order.
        if (!rstn) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            dout_i         <= '0;
            dout_q         <= '0;
            dout_valid     <= 1'b0;
            dout_sub_phase <= 1'b0;
            frame_done     <= 1'b0;
            err_overrun    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dout_valid     <= load_add | load_sub;
            dout_sub_phase <= load_sub;
            frame_done     <= done_d;

            // On a stall the output data keeps its last value.
            if (load_add) begin
                dout_i <= din_R_add;
                dout_q <= din_Q_add;
            end else if (load_sub) begin
                dout_i <= buf_i[cnt_q];
                dout_q <= buf_q[cnt_q];
            end

            // An input that arrives during the drain is dropped; only the flag records it.
            if (state_q == DRAIN && in_valid)
                err_overrun <= 1'b1;
        end
    end

    // NOTE: the sub buffer has no reset. Each entry is written in PASS before DRAIN reads it, so its reset contents never matter.
    always_ff @(posedge clk) begin
        if (load_add) begin
            buf_i[cnt_q] <= din_R_sub;
            buf_q[cnt_q] <= din_Q_sub;
        end
    end

endmodule

// File: tb/tb_bf_out_serializer.sv
// -----------------------------------------------------------------------------
// tb_bf_out_serializer
//
// Self-checking bench for bf_out_serializer.
//
// The stimulus task drives one cycle at a time and runs a small frame model.
// Whenever a vector is accepted, the model pushes the expected output vectors
// into a scoreboard queue.
//
// A separate monitor samples on the falling clock edge. Each time dout_valid
// is high it pops one entry from the queue and compares it with the outputs.
// -----------------------------------------------------------------------------
module tb_bf_out_serializer;

    localparam int DW = 10;
    localparam int NL = 16;
    localparam int BD = 16;

    typedef logic [NL-1:0][DW-1:0] vec_t;

    typedef struct {
        vec_t i;
        vec_t q;
        logic sub;
        logic done;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic in_valid = 1'b0;
    vec_t din_R_add = '0;
    vec_t din_R_sub = '0;
    vec_t din_Q_add = '0;
    vec_t din_Q_sub = '0;
    vec_t dout_i, dout_q;
    logic dout_valid, dout_sub_phase, frame_done, err_overrun;

    bf_out_serializer #(
        .DATA_WIDTH(DW),
        .NUM_IN_OUT(NL),
        .BLK_DEPTH (BD)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .din_R_add     (din_R_add),
        .din_R_sub     (din_R_sub),
        .din_Q_add     (din_Q_add),
        .din_Q_sub     (din_Q_sub),
        .dout_i        (dout_i),
        .dout_q        (dout_q),
        .dout_valid    (dout_valid),
        .dout_sub_phase(dout_sub_phase),
        .frame_done    (frame_done),
        .err_overrun   (err_overrun)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Frame model state
    vec_t m_bi[BD];
    vec_t m_bq[BD];
    int   m_cnt   = 0;
    int   m_drain = 0;
    logic m_ovr   = 1'b0;

    // Run-length tracking of dout_valid, used by the back-to-back test
    int run_len = 0;
    int max_run = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int base, input int step);
        vec_t v;
        for (int l = 0; l < NL; l++) v[l] = DW'(base + step * l);
        return v;
    endfunction

    // Monitor: compares each valid output against the scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            if (dout_valid) begin
                run_len++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got i=%h, expected no output", dout_i);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("dout_i", 256'(dout_i), 256'(e.i));
                    check("dout_q", 256'(dout_q), 256'(e.q));
                    check("dout_sub_phase", 256'(dout_sub_phase), 256'(e.sub));
                    check("frame_done", 256'(frame_done), 256'(e.done));
                end
            end else begin
                if (run_len > max_run) max_run = run_len;
                run_len = 0;
                check("frame_done_idle", 256'(frame_done), 256'(0));
            end
        end
    end

    // One clock of stimulus plus the model update for that edge.
    task automatic cycle(input logic v, input vec_t ai, input vec_t aq,
                         input vec_t si, input vec_t sq);
        in_valid  = v;
        din_R_add = ai;
        din_Q_add = aq;
        din_R_sub = si;
        din_Q_sub = sq;
        @(posedge clk);
        if (m_drain > 0) begin
            if (v) m_ovr = 1'b1;
            m_drain--;
        end else if (v) begin
            sb.push_back('{i: ai, q: aq, sub: 1'b0, done: 1'b0});
            m_bi[m_cnt] = si;
            m_bq[m_cnt] = sq;
            m_cnt++;
            if (m_cnt == BD) begin
                for (int k = 0; k < BD; k++)
                    sb.push_back('{i: m_bi[k], q: m_bq[k], sub: 1'b1, done: (k == BD - 1)});
                m_cnt   = 0;
                m_drain = BD;
            end
        end
        #1;
        in_valid = 1'b0;
        check("err_overrun", 256'(err_overrun), 256'(m_ovr));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, '0, '0);
    endtask

    // Vector k of a frame: add = fb+k, sub = 100+fb+k on lane 0.
    // The other lanes are offset so that a lane swap shows up.
    task automatic vec(input int fb, input int k);
        cycle(1'b1, mk(fb + k, 16), mk(-(fb + k), -1),
              mk(100 + fb + k, 16), mk(-(100 + fb + k), -1));
    endtask

    task automatic frame(input int fb);
        for (int k = 0; k < BD; k++) vec(fb, k);
        idle(BD);
    endtask

    initial begin
        // Power-on reset
        #1 rstn = 1'b0;
        #1;
        check("rst_dout_i", 256'(dout_i), 256'(0));
        check("rst_dout_valid", 256'(dout_valid), 256'(0));
        check("rst_err_overrun", 256'(err_overrun), 256'(0));
        @(negedge clk);
        rstn = 1'b1;

        // Reset in the middle of PASS, with cnt at 7
        for (int k = 0; k < 7; k++) vec(300, k);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check("midrst_dout_i", 256'(dout_i), 256'(0));
        check("midrst_dout_q", 256'(dout_q), 256'(0));
        check("midrst_dout_valid", 256'(dout_valid), 256'(0));
        check("midrst_sub_phase", 256'(dout_sub_phase), 256'(0));
        check("midrst_frame_done", 256'(frame_done), 256'(0));
        check("midrst_err_overrun", 256'(err_overrun), 256'(0));
        check("midrst_sb_empty", 256'(sb.size()), 256'(0));
        m_cnt   = 0;
        m_drain = 0;
        m_ovr   = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single frame. Its subs must be 100..115, with no stale output.
        frame(0);
        idle(2);

        // Three back-to-back frames
        max_run = 0;
        frame(20);
        frame(40);
        frame(60);
        idle(2);
        check("b2b_valid_run", 256'(max_run), 256'(3 * 2 * BD));
        check("b2b_err_overrun", 256'(err_overrun), 256'(0));

        // Stall for 3 cycles after the 5th vector
        for (int k = 0; k < 5; k++) vec(0, k);
        for (int s = 0; s < 3; s++) begin
            cycle(1'b0, '0, '0, '0, '0);
            check("stall_valid", 256'(dout_valid), 256'(0));
            check("stall_hold_i", 256'(dout_i), 256'(mk(4, 16)));
            check("stall_hold_q", 256'(dout_q), 256'(mk(-4, -1)));
        end
        for (int k = 5; k < BD; k++) vec(0, k);
        idle(BD);
        idle(2);

        // Overrun on DRAIN cycle 4. The drain must not change.
        for (int k = 0; k < BD; k++) vec(0, k);
        idle(3);
        cycle(1'b1, mk(7, 0), mk(7, 0), mk(9, 0), mk(9, 0));
        check("ovr_set", 256'(err_overrun), 256'(1));
        idle(BD - 4);
        idle(2);
        check("ovr_sticky", 256'(err_overrun), 256'(1));

        // Signed extremes on all lanes, I and Q
        for (int k = 0; k < BD; k++)
            cycle(1'b1, mk(-512, 0), mk(-512, 0), mk(511, 0), mk(511, 0));
        idle(BD);
        idle(2);
        check("extreme_sticky_ovr", 256'(err_overrun), 256'(1));

        check("final_sb_empty", 256'(sb.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
